cpu_clock_ctrl: RTL and testbench

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

---
 rtl/cpu_clock_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: derives a 50%-duty main_clk from the board clock with
// free-run and single-step modes. The switch and the button are synchronised,
// and the button is also debounced. Stopping always lands on a whole cycle of
// the downstream divide-by-2 stage (an even number of main_clk rising edges).
module cpu_clock_ctrl #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic run_sw,
  input  logic step_btn,
  input  logic halt,
  output logic main_clk,
  output logic running,
  output logic step_done
);

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [15:0] DB_M1  = 16'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP, STOPPING} state_t;

  state_t      state, state_n;
  logic        run_s1, run_s2;
  logic        btn_s1, btn_s2;
  logic        btn_acc;
  logic [15:0] db_cnt;
  logic        step_req;
  logic [15:0] phase, phase_n;
  logic        mclk_n;
  logic        parity, parity_n;
  logic        done_n;
  logic        tick;

  // two-flop synchronisers for the asynchronous switch and the raw button
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      run_s1 <= run_sw;
      run_s2 <= run_s1;
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
    end
  end

  // debounce: db_cnt counts consecutive samples that differ from the accepted
  // level; any sample equal to the accepted level restarts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_acc <= 1'b0;
      db_cnt  <= '0;
    end else if (btn_s2 == btn_acc) begin
      db_cnt  <= '0;
    end else if (db_cnt == DB_M1) begin
      btn_acc <= btn_s2;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + 16'd1;
    end
  end

  // Step request: the cycle in which the accepted level goes 0->1. It is taken
  // straight from the debounce registers, so it is seen in the same cycle as
  // the accept. A request the FSM does not take in that cycle is lost.
  assign step_req = btn_s2 & ~btn_acc & (db_cnt == DB_M1);

  assign tick = (phase == DIV_M1);

  // state, phase counter, main_clk, parity, and the registered status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      phase     <= '0;
      main_clk  <= 1'b0;
      parity    <= 1'b0;
      running   <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      main_clk  <= mclk_n;
      parity    <= parity_n;
      running   <= (state_n != IDLE);
      step_done <= done_n;
    end
  end

  // Next state and next datapath values. STEP and STOPPING share the exit
  // rule: leave on the falling edge that follows an even edge count. A STEP
  // starts at parity 0, so that exit gives exactly two rising edges.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    mclk_n   = main_clk;
    parity_n = parity;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        phase_n  = '0;
        mclk_n   = 1'b0;
        parity_n = 1'b0;
        if (run_s2 && !halt)
          state_n = RUN;
        else if (step_req && !halt)
          state_n = STEP;
      end
      RUN, STEP, STOPPING: begin
        if (tick) begin
          phase_n = '0;
          mclk_n  = ~main_clk;
          if (!main_clk)
            parity_n = ~parity;
        end else begin
          phase_n = phase + 16'd1;
        end
        if (state == RUN) begin
          if (!run_s2 || halt)
            state_n = STOPPING;
        end else if (tick && main_clk && !parity) begin
          state_n = IDLE;
          phase_n = '0;
          mclk_n  = 1'b0;
          done_n  = (state == STEP);
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
        mclk_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed checks of cpu_clock_ctrl with DIV=2, DEBOUNCE=4.
module tb_cpu_clock_ctrl;

  logic clk = 1'b0;
  logic resetn, run_sw, step_btn, halt;
  logic main_clk, running, step_done;

  int n_chk  = 0;
  int n_pass = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int seen_run;

  cpu_clock_ctrl #(.DIV(2), .DEBOUNCE(4)) dut (
    .clk(clk), .resetn(resetn), .run_sw(run_sw), .step_btn(step_btn),
    .halt(halt), .main_clk(main_clk), .running(running), .step_done(step_done)
  );

  always #5 clk = ~clk;

  // edge and pulse monitors
  always @(posedge main_clk) rise_cnt <= rise_cnt + 1;
  always @(negedge clk) if (step_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance n clocks, sampling 1ns after the edge; remember if running was seen
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (running) seen_run = 1;
    end
  endtask

  // cycles until main_clk leaves level lvl (bounded)
  task automatic level_len(input logic lvl, output int n);
    n = 0;
    while (main_clk == lvl && n < 50) begin
      cyc(1);
      n++;
    end
  endtask

  int n, base, r0, d0, found;
  logic prev;

  initial begin
    resetn = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_main_clk", main_clk, 0);
    chk("rst_running", running, 0);
    chk("rst_step_done", step_done, 0);
    cyc(3);
    resetn = 1'b1;
    cyc(3);

    // free run: running after sync + state, then 2-high/2-low main_clk
    base = rise_cnt;
    run_sw = 1'b1;
    n = 0;
    while (!running && n < 8) begin cyc(1); n++; end
    chk("run_latency", n, 3);
    level_len(1'b0, n);
    level_len(1'b1, n);
    chk("run_high", n, 2);
    level_len(1'b0, n);
    chk("run_low", n, 2);
    level_len(1'b1, n);
    chk("run_high2", n, 2);

    // drop run_sw right after a rising edge that left parity=1
    found = 0;
    prev = main_clk;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (!prev && main_clk && (((rise_cnt - base) % 2) == 1)) found = 1;
      prev = main_clk;
    end
    chk("odd_rise_found", found, 1);
    run_sw = 1'b0;
    r0 = rise_cnt;
    d0 = done_cnt;
    n = 0;
    while (running && n < 40) begin cyc(1); n++; end
    chk("stop_latency", n, 6);
    chk("stop_extra_rises", rise_cnt - r0, 1);
    chk("stop_even", (rise_cnt - base) % 2, 0);
    chk("stop_main_clk", main_clk, 0);
    cyc(10);
    chk("stop_quiet", rise_cnt - r0, 1);
    chk("stop_no_done", done_cnt - d0, 0);

    // 3-cycle bounce: shorter than DEBOUNCE, no step
    r0 = rise_cnt; d0 = done_cnt; seen_run = 0;
    step_btn = 1'b1; cyc(3); step_btn = 1'b0; cyc(20);
    chk("short_rises", rise_cnt - r0, 0);
    chk("short_done", done_cnt - d0, 0);
    chk("short_running", seen_run, 0);

    // clean 10-cycle press: one step of two rising edges
    r0 = rise_cnt; d0 = done_cnt; seen_run = 0;
    step_btn = 1'b1; cyc(10); step_btn = 1'b0; cyc(30);
    chk("step_rises", rise_cnt - r0, 2);
    chk("step_done_cycles", done_cnt - d0, 1);
    chk("step_seen_running", seen_run, 1);
    chk("step_end_running", running, 0);
    chk("step_end_main_clk", main_clk, 0);

    // second clean press accepted on STEP's last cycle is dropped
    r0 = rise_cnt; d0 = done_cnt;
    step_btn = 1'b1; cyc(4); step_btn = 1'b0; cyc(4);
    step_btn = 1'b1; cyc(10); step_btn = 1'b0; cyc(30);
    chk("dbl_rises", rise_cnt - r0, 2);
    chk("dbl_done", done_cnt - d0, 1);

    // press while halted in IDLE is discarded, not deferred
    r0 = rise_cnt; d0 = done_cnt; seen_run = 0;
    halt = 1'b1;
    step_btn = 1'b1; cyc(10); step_btn = 1'b0; cyc(10);
    halt = 1'b0; cyc(20);
    chk("halt_rises", rise_cnt - r0, 0);
    chk("halt_done", done_cnt - d0, 0);
    chk("halt_running", seen_run, 0);

    // halt during RUN stops on an even edge count
    base = rise_cnt;
    run_sw = 1'b1;
    cyc(12);
    halt = 1'b1;
    n = 0;
    while (running && n < 40) begin cyc(1); n++; end
    chk("halt_run_stopped", running, 0);
    chk("halt_run_even", (rise_cnt - base) % 2, 0);
    chk("halt_run_main_clk", main_clk, 0);
    run_sw = 1'b0; cyc(4); halt = 1'b0; cyc(4);

    // asynchronous reset mid-RUN while main_clk=1
    run_sw = 1'b1;
    n = 0;
    while (!(running && main_clk) && n < 40) begin cyc(1); n++; end
    chk("pre_rst_high", main_clk, 1);
    resetn = 1'b0;
    run_sw = 1'b0;
    #2;
    chk("async_rst_main_clk", main_clk, 0);
    chk("async_rst_running", running, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    r0 = rise_cnt; seen_run = 0;
    cyc(20);
    chk("post_rst_rises", rise_cnt - r0, 0);
    chk("post_rst_running", seen_run, 0);

    // button held through reset steps only after debounce
    step_btn = 1'b1;
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    r0 = rise_cnt; d0 = done_cnt; seen_run = 0;
    cyc(5);
    chk("held_early_running", seen_run, 0);
    cyc(30);
    chk("held_rises", rise_cnt - r0, 2);
    chk("held_done", done_cnt - d0, 1);
    step_btn = 1'b0;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
